// File: rtl/obstacle_pkg.sv
// Shared types and default constants for the obstacle sensor array.
// Holds the per-channel debounce state encoding.
package obstacle_pkg;

    localparam int DEF_N_CH            = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1000;
    localparam int DEF_CNT_W           = 16;

    typedef enum logic [1:0] {
        ST_CLEAR    = 2'd0,
        ST_CONFIRM  = 2'd1,
        ST_DETECTED = 2'd2,
        ST_RELEASE  = 2'd3
    } ch_state_t;

endpackage

// File: rtl/obstacle_debounce_ch.sv
// One sensor channel: 2-flop synchronizer, debounce FSM and edge pulses.
// The LED and pulse outputs are registered alongside the state.
module obstacle_debounce_ch
    import obstacle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic pin,
    output logic led,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       sync;
    ch_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             obs;

    // Pin is active-low, so an obstacle is a low second-stage sample.
    assign obs = ~sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            state <= ST_CLEAR;
            cnt   <= '0;
            led   <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            rise <= 1'b0;
            fall <= 1'b0;
            if (!en) begin
                // Disabling drops a lit channel immediately; led doubles as "was lit".
                state <= ST_CLEAR;
                cnt   <= '0;
                led   <= 1'b0;
                fall  <= led;
            end else begin
                case (state)
                    ST_CLEAR: begin
                        if (obs) begin
                            state <= ST_CONFIRM;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt   <= '0;
                        end
                    end
                    ST_CONFIRM: begin
                        if (!obs) begin
                            state <= ST_CLEAR;
                            cnt   <= '0;
                        end else if (cnt == CNT_MAX) begin
                            state <= ST_DETECTED;
                            cnt   <= '0;
                            led   <= 1'b1;
                            rise  <= 1'b1;
                        end else begin
                            cnt   <= cnt + CNT_ONE;
                        end
                    end
                    ST_DETECTED: begin
                        if (!obs) begin
                            state <= ST_RELEASE;
                            cnt   <= CNT_ONE;
                        end
                    end
                    ST_RELEASE: begin
                        if (obs) begin
                            state <= ST_DETECTED;
                            cnt   <= '0;
                        end else if (cnt == CNT_MAX) begin
                            state <= ST_CLEAR;
                            cnt   <= '0;
                            led   <= 1'b0;
                            fall  <= 1'b1;
                        end else begin
                            cnt   <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                        led   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/obstacle_sensor_array.sv
// Array of debounced IR obstacle channels with sticky flags and
// combinational summary (any / count) of the registered LED vector.
module obstacle_sensor_array
    import obstacle_pkg::*;
#(
    parameter int N_CH            = DEF_N_CH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CH-1:0]            sensor_input,
    input  logic                       en,
    input  logic                       clr_latched,
    output logic [N_CH-1:0]            led_output,
    output logic [N_CH-1:0]            det_rise,
    output logic [N_CH-1:0]            det_fall,
    output logic [N_CH-1:0]            latched,
    output logic                       any_obstacle,
    output logic [$clog2(N_CH+1)-1:0]  obstacle_count
);

    localparam int OC_W = $clog2(N_CH + 1);

    for (genvar i = 0; i < N_CH; i++) begin : ch_g
        obstacle_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en),
            .pin  (sensor_input[i]),
            .led  (led_output[i]),
            .rise (det_rise[i]),
            .fall (det_fall[i])
        );
    end

    // Set is OR'd after the clear mask so a coincident rise survives the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            latched <= '0;
        end else begin
            latched <= (latched & ~{N_CH{clr_latched}}) | det_rise;
        end
    end

    assign any_obstacle = |led_output;

    always_comb begin
        obstacle_count = '0;
        for (int i = 0; i < N_CH; i++) begin
            obstacle_count = obstacle_count + OC_W'(led_output[i]);
        end
    end

endmodule

// File: tb/tb_obstacle_sensor_array.sv
// Directed bench for obstacle_sensor_array (N_CH=4, DEBOUNCE_CYCLES=4).
// Table of per-edge vectors plus hand sequences for reset / enable corners.
module tb_obstacle_sensor_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sensor_input;
    logic       en;
    logic       clr_latched;
    logic [3:0] led_output;
    logic [3:0] det_rise;
    logic [3:0] det_fall;
    logic [3:0] latched;
    logic       any_obstacle;
    logic [2:0] obstacle_count;

    int checks   = 0;
    int failures = 0;

    obstacle_sensor_array #(
        .N_CH           (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sensor_input  (sensor_input),
        .en            (en),
        .clr_latched   (clr_latched),
        .led_output    (led_output),
        .det_rise      (det_rise),
        .det_fall      (det_fall),
        .latched       (latched),
        .any_obstacle  (any_obstacle),
        .obstacle_count(obstacle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pin;
        logic       clr;
        logic [3:0] led;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] lat;
        logic [2:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add_n(input int n, input logic [3:0] pin, input logic clr,
                         input logic [3:0] led, input logic [3:0] rise,
                         input logic [3:0] fall, input logic [3:0] lat,
                         input logic [2:0] cnt);
        vec_t v;
        v.pin = pin; v.clr = clr; v.led = led; v.rise = rise;
        v.fall = fall; v.lat = lat; v.cnt = cnt;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] led, input logic [3:0] rise,
                           input logic [3:0] fall, input logic [3:0] lat, input logic [2:0] cnt);
        chk(name, {13'd0, any_obstacle, obstacle_count, latched, det_fall, det_rise, led_output},
                  {13'd0, (cnt != 3'd0), cnt, lat, fall, rise, led});
    endtask

    initial begin
        // Edge k applies record k's inputs; outputs are checked 1 ns after that edge.
        add_n(5, 4'hE, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);  // ch0 debounce
        add_n(1, 4'hE, 0, 4'h1, 4'h1, 4'h0, 4'h0, 3'd1);  // edge 6: detect
        add_n(1, 4'hE, 0, 4'h1, 4'h0, 4'h0, 4'h1, 3'd1);
        add_n(2, 4'hF, 0, 4'h1, 4'h0, 4'h0, 4'h1, 3'd1);  // short release glitch
        add_n(4, 4'hE, 0, 4'h1, 4'h0, 4'h0, 4'h1, 3'd1);
        add_n(5, 4'hF, 0, 4'h1, 4'h0, 4'h0, 4'h1, 3'd1);  // real release
        add_n(1, 4'hF, 0, 4'h0, 4'h0, 4'h1, 4'h1, 3'd0);
        add_n(1, 4'hF, 0, 4'h0, 4'h0, 4'h0, 4'h1, 3'd0);
        add_n(1, 4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);  // clear sticky
        add_n(1, 4'hF, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);
        add_n(3, 4'hE, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);  // 3-cycle glitch
        add_n(5, 4'hF, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);
        add_n(5, 4'h2, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);  // ch0,2,3 together
        add_n(1, 4'h2, 0, 4'hD, 4'hD, 4'h0, 4'h0, 3'd3);
        add_n(1, 4'h2, 0, 4'hD, 4'h0, 4'h0, 4'hD, 3'd3);
        add_n(5, 4'hF, 0, 4'hD, 4'h0, 4'h0, 4'hD, 3'd3);
        add_n(1, 4'hF, 0, 4'h0, 4'h0, 4'hD, 4'hD, 3'd0);
        add_n(1, 4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);

        rst_n = 1'b0; sensor_input = 4'h0; en = 1'b1; clr_latched = 1'b1;
        tick(); tick();
        chk_all("reset_state", 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);
        sensor_input = 4'hF; clr_latched = 1'b0;
        tick();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            sensor_input = vecs[i].pin;
            clr_latched  = vecs[i].clr;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].led, vecs[i].rise,
                    vecs[i].fall, vecs[i].lat, vecs[i].cnt);
        end
        clr_latched = 1'b0;

        // Rise on ch1 coinciding with a clear request: set wins.
        sensor_input = 4'hD;
        for (int k = 0; k < 5; k++) tick();
        chk("ch1_pre_rise_led", led_output, 4'h0);
        tick();
        chk("ch1_rise", {det_rise, led_output}, {4'h2, 4'h2});
        clr_latched = 1'b1;
        tick();
        chk("set_wins_clear", latched, 4'h2);
        tick();
        chk("clear_alone", latched, 4'h0);
        clr_latched = 1'b0;
        sensor_input = 4'hF;
        for (int k = 0; k < 5; k++) tick();
        chk("ch1_pre_fall", {det_fall, led_output}, {4'h0, 4'h2});
        tick();
        chk("ch1_fall", {det_fall, led_output}, {4'h2, 4'h0});

        // Reset in CONFIRM discards progress, then en drop while DETECTED.
        sensor_input = 4'hE;
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0; en = 1'b0; clr_latched = 1'b0;
        tick();
        chk_all("mid_confirm_reset", 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);
        rst_n = 1'b1; en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("post_reset_wait%0d", k), {det_rise, led_output}, 8'h00);
        end
        tick();
        chk("post_reset_detect", {det_rise, led_output}, {4'h1, 4'h1});
        en = 1'b0;
        tick();
        chk("en_drop_fall", {det_rise, det_fall, led_output}, {4'h0, 4'h1, 4'h0});
        tick();
        chk("en_drop_single", {det_fall, led_output}, {4'h0, 4'h0});
        chk("en_drop_any", {any_obstacle, obstacle_count}, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
